// File: rtl/resolucao_noite.sv
// Night resolution for a 5-player werewolf game: applies the wolf attack against the
// protector's choice, updates the alive mask, then counts factions to detect game end.
module resolucao_noite (
  input  logic       i_clock,
  input  logic       i_rst_global,
  input  logic       i_novo_jogo,
  input  logic       i_iniciar,
  input  logic [9:0] i_jogo,
  input  logic [2:0] i_atacado,
  input  logic [2:0] i_protegido,
  output logic [4:0] o_vivos,
  output logic [2:0] o_morto_noite,
  output logic       o_houve_morte,
  output logic       o_pronto,
  output logic       o_fim_jogo,
  output logic [1:0] o_vencedor,
  output logic [2:0] o_db_estado
);

  // Handshake: i_iniciar is a request taken only in IDLE while the game is running;
  // o_pronto pulses for one cycle when every result output is valid. There is no
  // back-pressure: a request seen in any other state, or after game over, is dropped.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_AVALIA   = 3'd1,
    S_CONTA    = 3'd2,
    S_VERIFICA = 3'd3,
    S_PRONTO   = 3'd4
  } estado_t;

  localparam logic [2:0] IDX_NENHUM = 3'b111;
  localparam logic [2:0] IDX_ULTIMO = 3'd4;
  localparam logic [2:0] N_JOG_IDX  = 3'd5;
  localparam logic [1:0] CLASSE_LOBO = 2'b01;

  estado_t    r_estado;
  estado_t    w_prox;

  logic [4:0] r_vivos;
  logic [2:0] r_morto_noite;
  logic       r_houve_morte;
  logic       r_fim_jogo;
  logic [1:0] r_vencedor;

  logic [2:0] r_atacado;
  logic [2:0] r_protegido;
  logic [2:0] r_k;
  logic [2:0] r_lobos;
  logic [2:0] r_aldeoes;

  logic       w_limpa;
  logic       w_aceita;
  logic [7:0] w_vivos_ext;
  logic [15:0] w_jogo_ext;
  logic       w_alvo_vivo;
  logic       w_mata;
  logic [4:0] w_mascara;
  logic       w_vivo_k;
  logic [1:0] w_classe_k;

  assign w_limpa  = i_rst_global | i_novo_jogo;
  assign w_aceita = (r_estado == S_IDLE) && i_iniciar && !r_fim_jogo;

  // Zero-extended views let 3-bit indices 5..7 read as "dead"/"no role" safely.
  assign w_vivos_ext = {3'b000, r_vivos};
  assign w_jogo_ext  = {6'b000000, i_jogo};

  assign w_alvo_vivo = w_vivos_ext[r_atacado];
  assign w_mata      = (r_atacado < N_JOG_IDX) && w_alvo_vivo && (r_atacado != r_protegido);
  assign w_mascara   = 5'd1 << r_atacado;

  assign w_vivo_k    = w_vivos_ext[r_k];
  assign w_classe_k  = w_jogo_ext[{r_k, 1'b0} +: 2];

  always_ff @(posedge i_clock) begin
    if (w_limpa) begin
      r_estado <= S_IDLE;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      S_IDLE:     if (w_aceita) w_prox = S_AVALIA;
      S_AVALIA:   w_prox = S_CONTA;
      S_CONTA:    if (r_k == IDX_ULTIMO) w_prox = S_VERIFICA;
      S_VERIFICA: w_prox = S_PRONTO;
      S_PRONTO:   w_prox = S_IDLE;
      default:    w_prox = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (w_limpa) begin
      r_vivos       <= 5'b11111;
      r_morto_noite <= IDX_NENHUM;
      r_houve_morte <= 1'b0;
      r_fim_jogo    <= 1'b0;
      r_vencedor    <= 2'b00;
      r_atacado     <= 3'd0;
      r_protegido   <= 3'd0;
      r_k           <= 3'd0;
      r_lobos       <= 3'd0;
      r_aldeoes     <= 3'd0;
    end else begin
      case (r_estado)
        S_IDLE: begin
          if (w_aceita) begin
            r_atacado   <= i_atacado;
            r_protegido <= i_protegido;
          end
        end
        S_AVALIA: begin
          if (w_mata) begin
            r_vivos       <= r_vivos & ~w_mascara;
            r_morto_noite <= r_atacado;
            r_houve_morte <= 1'b1;
          end else begin
            r_morto_noite <= IDX_NENHUM;
            r_houve_morte <= 1'b0;
          end
          r_k       <= 3'd0;
          r_lobos   <= 3'd0;
          r_aldeoes <= 3'd0;
        end
        S_CONTA: begin
          // Counters top out at 5 players, so 3 bits never wrap.
          if (w_vivo_k) begin
            if (w_classe_k == CLASSE_LOBO) begin
              r_lobos <= r_lobos + 3'd1;
            end else begin
              r_aldeoes <= r_aldeoes + 3'd1;
            end
          end
          r_k <= r_k + 3'd1;
        end
        S_VERIFICA: begin
          if (r_lobos == 3'd0) begin
            r_vencedor <= 2'b01;
            r_fim_jogo <= 1'b1;
          end else if (r_lobos >= r_aldeoes) begin
            r_vencedor <= 2'b10;
            r_fim_jogo <= 1'b1;
          end else begin
            r_vencedor <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_vivos       = r_vivos;
  assign o_morto_noite = r_morto_noite;
  assign o_houve_morte = r_houve_morte;
  assign o_fim_jogo    = r_fim_jogo;
  assign o_vencedor    = r_vencedor;
  assign o_pronto      = (r_estado == S_PRONTO);
  assign o_db_estado   = r_estado;

endmodule
